// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the single-clock FIFO family.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH         = 8;
    localparam int unsigned DEFAULT_ADDR_WIDTH         = 4;
    localparam int unsigned DEFAULT_ALMOST_EMPTY_LEVEL = 2;
    localparam int unsigned DEFAULT_ALMOST_FULL_MARGIN = 2;

    function automatic int unsigned clog2_ceil(input longint unsigned value);
        int unsigned     n = 0;
        longint unsigned v = 1;
        while (v < value) begin
            v = v << 1;
            n++;
        end
        return n;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than the address.
    function automatic int unsigned FIFO_LEVEL_W(input int unsigned addr_width);
        return clog2_ceil((64'd1 << addr_width) + 64'd1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port, one read port that is either
// combinational (first-word-fall-through) or registered.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter bit          FWFT       = 1'b1
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    if (FWFT) begin : g_async_read
        logic unused_read_ctrl;
        assign unused_read_ctrl = &{1'b0, read_en, areset_n};
        assign read_data        = mem[read_addr];
    end else begin : g_reg_read
        // Read samples the old word when it coincides with a write to the same slot.
        always_ff @(posedge clk or negedge areset_n) begin
            if (!areset_n) begin
                read_data <= '0;
            end else if (read_en) begin
                read_data <= mem[read_addr];
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy and threshold flags,
// synchronous flush and sticky overflow/underflow errors.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ALMOST_FULL_LEVEL  = fifo_depth(ADDR_WIDTH) - DEFAULT_ALMOST_FULL_MARGIN,
    parameter int unsigned ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL,
    parameter bit          FWFT               = 1'b1
) (
    input  logic                                clk,
    input  logic                                areset_n,
    input  logic                                flush,
    input  logic [DATA_WIDTH-1:0]               write_data,
    input  logic                                write_en,
    output logic                                full,
    output logic                                almost_full,
    output logic [DATA_WIDTH-1:0]               read_data,
    input  logic                                read_en,
    output logic                                read_valid,
    output logic                                empty,
    output logic                                almost_empty,
    output logic [FIFO_LEVEL_W(ADDR_WIDTH)-1:0] level,
    output logic                                overflow,
    output logic                                underflow,
    input  logic                                clear_errors
);

    localparam int unsigned          DEPTH   = fifo_depth(ADDR_WIDTH);
    localparam int unsigned          PTR_W   = FIFO_LEVEL_W(ADDR_WIDTH);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0]     WRAP    = PTR_W'(1) << ADDR_WIDTH;
    localparam logic [PTR_W-1:0]     AF_LVL  = PTR_W'(ALMOST_FULL_LEVEL);
    localparam logic [PTR_W-1:0]     AE_LVL  = PTR_W'(ALMOST_EMPTY_LEVEL);

    if (!(ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL && ALMOST_FULL_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("sync_fifo: need ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
    end

    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic             read_accept;
    logic             write_accept;
    logic             write_error;
    logic             read_error;

    assign empty        = (write_ptr == read_ptr);
    // Same address, opposite wrap bit.
    assign full         = ((write_ptr ^ read_ptr) == WRAP);
    assign level        = write_ptr - read_ptr;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    always_comb begin
        read_accept  = 1'b0;
        write_accept = 1'b0;
        write_error  = 1'b0;
        read_error   = 1'b0;
        if (!flush) begin
            read_accept  = read_en && !empty;
            write_accept = write_en && (!full || read_accept);
            write_error  = write_en && full && !read_accept;
            read_error   = read_en && empty;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else if (flush) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else begin
            if (write_accept) begin
                write_ptr <= write_ptr + PTR_ONE;
            end
            if (read_accept) begin
                read_ptr <= read_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_error) begin
                overflow <= 1'b1;
            end else if (clear_errors) begin
                overflow <= 1'b0;
            end
            if (read_error) begin
                underflow <= 1'b1;
            end else if (clear_errors) begin
                underflow <= 1'b0;
            end
        end
    end

    if (FWFT) begin : g_fwft_valid
        assign read_valid = !empty;
    end else begin : g_reg_valid
        logic read_valid_q;
        always_ff @(posedge clk or negedge areset_n) begin
            if (!areset_n) begin
                read_valid_q <= 1'b0;
            end else if (flush) begin
                read_valid_q <= 1'b0;
            end else begin
                read_valid_q <= read_accept;
            end
        end
        assign read_valid = read_valid_q;
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk        (clk),
        .areset_n   (areset_n),
        .write_en   (write_accept),
        .write_addr (write_ptr[ADDR_WIDTH-1:0]),
        .write_data (write_data),
        .read_en    (read_accept),
        .read_addr  (read_ptr[ADDR_WIDTH-1:0]),
        .read_data  (read_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a FWFT and a registered-read instance share stimulus and a queue model.
module tb_sync_fifo;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       areset_n;
    logic       flush;
    logic [7:0] write_data;
    logic       write_en;
    logic       read_en;
    logic       clear_errors;

    logic       f_full, f_afull, f_rvalid, f_empty, f_aempty, f_ovf, f_unf;
    logic [7:0] f_rdata;
    logic [2:0] f_level;
    logic       r_full, r_afull, r_rvalid, r_empty, r_aempty, r_ovf, r_unf;
    logic [7:0] r_rdata;
    logic [2:0] r_level;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] mq[$];
    logic       m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_FULL_LEVEL(3),
        .ALMOST_EMPTY_LEVEL(1), .FWFT(1'b1)
    ) dut_f (
        .clk(clk), .areset_n(areset_n), .flush(flush), .write_data(write_data),
        .write_en(write_en), .full(f_full), .almost_full(f_afull), .read_data(f_rdata),
        .read_en(read_en), .read_valid(f_rvalid), .empty(f_empty), .almost_empty(f_aempty),
        .level(f_level), .overflow(f_ovf), .underflow(f_unf), .clear_errors(clear_errors)
    );

    sync_fifo #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .ALMOST_FULL_LEVEL(3),
        .ALMOST_EMPTY_LEVEL(1), .FWFT(1'b0)
    ) dut_r (
        .clk(clk), .areset_n(areset_n), .flush(flush), .write_data(write_data),
        .write_en(write_en), .full(r_full), .almost_full(r_afull), .read_data(r_rdata),
        .read_en(read_en), .read_valid(r_rvalid), .empty(r_empty), .almost_empty(r_aempty),
        .level(r_level), .overflow(r_ovf), .underflow(r_unf), .clear_errors(clear_errors)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
    endtask

    task automatic check_state();
        int unsigned n;
        n = mq.size();
        check_eq("f_level", 32'(f_level), n);
        check_eq("f_full", 32'(f_full), 32'(n == DEPTH));
        check_eq("f_empty", 32'(f_empty), 32'(n == 0));
        check_eq("f_afull", 32'(f_afull), 32'(n >= 3));
        check_eq("f_aempty", 32'(f_aempty), 32'(n <= 1));
        check_eq("f_ovf", 32'(f_ovf), 32'(m_ovf));
        check_eq("f_unf", 32'(f_unf), 32'(m_unf));
        check_eq("f_rvalid", 32'(f_rvalid), 32'(n != 0));
        if (n != 0) check_eq("f_head", 32'(f_rdata), 32'(mq[0]));
        check_eq("r_level", 32'(r_level), n);
        check_eq("r_full", 32'(r_full), 32'(n == DEPTH));
        check_eq("r_empty", 32'(r_empty), 32'(n == 0));
        check_eq("r_afull", 32'(r_afull), 32'(n >= 3));
        check_eq("r_aempty", 32'(r_aempty), 32'(n <= 1));
        check_eq("r_ovf", 32'(r_ovf), 32'(m_ovf));
        check_eq("r_unf", 32'(r_unf), 32'(m_unf));
        check_eq("r_rvalid", 32'(r_rvalid), 32'(m_rv));
        check_eq("r_rdata", 32'(r_rdata), 32'(m_rd));
    endtask

    task automatic model_step(input logic we, input logic [7:0] wd, input logic re,
                              input logic fl, input logic ce);
        logic racc, werr, rerr;
        if (fl) begin
            mq.delete();
            m_rv = 1'b0;
            if (ce) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            return;
        end
        racc = re && (mq.size() != 0);
        werr = we && (mq.size() == DEPTH) && !racc;
        rerr = re && (mq.size() == 0);
        if (racc) begin
            check_eq("f_pop", 32'(f_rdata), 32'(mq[0]));
            m_rd = mq.pop_front();
        end
        m_rv = racc;
        if (we && !werr) mq.push_back(wd);
        if (werr) m_ovf = 1'b1;
        else if (ce) m_ovf = 1'b0;
        if (rerr) m_unf = 1'b1;
        else if (ce) m_unf = 1'b0;
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re,
                         input logic fl, input logic ce);
        @(negedge clk);
        check_state();
        write_en     = we;
        write_data   = wd;
        read_en      = re;
        flush        = fl;
        clear_errors = ce;
        model_step(we, wd, re, fl, ce);
        @(posedge clk);
    endtask

    task automatic wr(input logic [7:0] d);  cycle(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
    task automatic rd();                     cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask
    task automatic idle();                   cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); endtask
    task automatic clr();                    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        areset_n = 1'b0; flush = 1'b0; write_data = '0;
        write_en = 1'b0; read_en = 1'b0; clear_errors = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state();
        areset_n = 1'b1;

        // Fill, overflow, clear, drain in order.
        for (int i = 0; i < 4; i++) wr(fill[i]);
        wr(8'h55);
        clr();
        for (int i = 0; i < 4; i++) rd();
        idle();

        // Simultaneous read+write at full.
        for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
        cycle(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) rd();

        // Simultaneous read+write on empty: only the write lands.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        rd();
        clr();

        // Registered-read latency and hold.
        wr(8'h7E);
        rd();
        idle();
        idle();
        // Read while empty with clear_errors: the new error wins.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle();
        clr();

        // Flush with pending write/read, overflow kept.
        for (int i = 0; i < 4; i++) wr(8'h01 + 8'(i));
        wr(8'hEE);
        rd();
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        idle();
        clr();

        // Asynchronous reset mid-cycle.
        wr(8'h3C);
        wr(8'h4D);
        cycle(1'b1, 8'h5E, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_state();
        #2 areset_n = 1'b0;
        #1;
        write_en = 1'b0; read_en = 1'b0; flush = 1'b0; clear_errors = 1'b0;
        model_reset();
        check_state();
        @(negedge clk);
        areset_n = 1'b1;
        idle();

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end
        idle();
        @(negedge clk);
        check_state();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised successor to the team's dual-clock FIFO, for intra-domain buffering (CPU-to-peripheral queues, UART TX/RX staging).
- Uses all DEPTH entries; full is not one entry early.
- Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, sticky overflow/underflow error flags and a selectable read mode (first-word-fall-through or registered).

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserted when level >= this value
ALMOST_EMPTY_LEVEL, 2, almost_empty asserted when level <= this value
FWFT, 1, 1 = read_data shows the head word combinationally; 0 = read_data registered, valid one cycle after an accepted read

Ports:
clk  input  1  single clock, rising edge
areset_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of contents and pointers
write_data  input  DATA_WIDTH  word to enqueue
write_en  input  1  enqueue request
full  output  1  level == DEPTH
almost_full  output  1  level >= ALMOST_FULL_LEVEL
read_data  output  DATA_WIDTH  head word (FWFT=1) or last popped word (FWFT=0)
read_en  input  1  dequeue request
read_valid  output  1  FWFT=1: equals !empty; FWFT=0: pulses one cycle after an accepted read
empty  output  1  level == 0
almost_empty  output  1  level <= ALMOST_EMPTY_LEVEL
level  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty
clear_errors  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset is asynchronous on the falling edge of areset_n; release is synchronous to clk.
- Reset values: pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0, overflow 0, underflow 0, read_valid 0, registered read_data 0. Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits wide. The MSB is a wrap bit.
  - empty: pointers equal.
  - full: addresses equal and wrap bits differ.
  - level = write_ptr - read_ptr, modulo 2**(ADDR_WIDTH+1).
- Accepted write: write_en && (!full || read_accept). Writes mem[write_ptr], then increments write_ptr.
- Accepted read: read_en && !empty. Increments read_ptr.
  - FWFT=0: read_data <= mem[read_ptr] on the same edge, and read_valid = 1 in the next cycle.
- Simultaneous read and write:
  - When full: both are accepted; level stays at DEPTH and full stays 1.
  - When empty: only the write is accepted; underflow is set; the written word appears as head next cycle.
- Write while full with no read: data is dropped, overflow <= 1, pointers unchanged.
- Read while empty: underflow <= 1, pointers unchanged. FWFT=0: read_valid stays 0 and read_data holds.
- Priority, highest first: areset_n, flush, then normal operation.
  - flush: pointers <- 0, level <- 0, read_valid <- 0. Any write_en/read_en in the same cycle is ignored. Sticky flags are not cleared.
- clear_errors clears the sticky flags. If a new error occurs in the same cycle, set wins.
- All flags and level are registered-pointer derived, so they update on the edge after the access (one-cycle latency, no combinational path from write_en/read_en to flags).
- Throughput: one write and one read per cycle, sustained.
- Elaboration check: ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH; an illegal setting triggers $error.

Decomposition:
- Shared package fifo_pkg holds:
  - clog2-style helper for level width
  - FIFO_LEVEL_W(ADDR_WIDTH) constant function
  - default threshold constants
- Sub-module fifo_ram holds the storage:
  - DATA_WIDTH x DEPTH array
  - one synchronous write port
  - one read port, asynchronous for FWFT=1 or registered for FWFT=0
- sync_fifo contains pointers, flags and error logic only.

Test Plan:
- Reset/fill/drain (DW=8, AW=2): write 0x11,0x22,0x33,0x44 -> full=1 after the 4th edge, level=4, almost_full=1. Read 4 -> data in order, empty=1, level=0.
- Overflow: with the FIFO full, write 0x55 without a read -> overflow=1, level stays 4, later reads return 0x11..0x44. Then clear_errors -> overflow=0.
- Simultaneous read+write at full: read_en=write_en=1 with 0x66 -> level stays 4, head advances to 0x22, 0x66 later emerges last.
- Underflow and empty simultaneous: read_en=write_en=1 on empty with 0xA5 -> underflow=1, level=1, head=0xA5 next cycle.
- FWFT=0 latency: write 0x7E, pulse read_en -> read_valid=1 and read_data=0x7E exactly one cycle later, held until the next accepted read.
- Flush and async reset mid-operation:
  - level=3, flush with write_en=1 -> level=0, empty=1, overflow unchanged.
  - Drop areset_n mid-cycle -> outputs reach reset values without waiting for a clk edge.
